fence_t_sequencer: RTL and testbench
====================================

Name: fence_t_sequencer

Overview:
- Drives the temporal-fence (fence.t) microarchitectural flush sequence for one CVA6 core.
- On a commit-stage request it flushes the D-cache, holds microarchitectural reset, then pads so total fence latency is constant.
- The dual-core flush-equivalence checker observes this sequence through its state, done and active outputs.
- Sits beside controller_i; consumes fence_t_pad/src_sel from the CSR file.

Parameters:
PadWidth, 32, width of pad target and elapsed-cycle counter
RstCycles, 4, cycles rst_uarch_o is held high (min 1)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
fence_t_i  input  1  fence.t request pulse from commit
fence_t_pad_i  input  PadWidth  target total fence latency in cycles (CSR)
fence_t_src_sel_i  input  1  0: count from fence start; 1: count from RST_UARCH entry
flush_dcache_ack_i  input  1  D-cache flush complete
flush_dcache_o  output  1  D-cache flush request
rst_uarch_o  output  1  reset predictors/queues/TLBs
halt_o  output  1  stall fetch and commit
fence_active_o  output  1  sequence in progress (state != IDLE)
done_o  output  1  pulse on cycle the FSM returns to IDLE
dropped_o  output  1  pulse when fence_t_i arrives while busy
state_o  output  2  IDLE=0, FLUSH_DCACHE=1, RST_UARCH=2, PAD=3
elapsed_o  output  PadWidth  current cnt_q

Behaviour:
- Reset: state IDLE; cnt_q, rst_cnt_q, pad_q, src_q = 0; all outputs 0. Reset mid-sequence aborts next edge; no done_o.
- IDLE: fence_t_i -> FLUSH_DCACHE; latch pad_q <= fence_t_pad_i, src_q <= fence_t_src_sel_i, cnt_q <= 0. Later CSR changes have no effect on a running sequence.
- FLUSH_DCACHE: flush_dcache_o = 1 (Moore). flush_dcache_ack_i sampled high -> RST_UARCH, rst_cnt_q <= 0. Ack in the first cycle is legal: minimum 1 cycle in the state. Ack outside FLUSH_DCACHE is ignored.
- RST_UARCH: rst_uarch_o = 1 for exactly RstCycles cycles; rst_cnt_q increments.
  - On the last cycle, if cnt_q + 1 >= pad_q -> IDLE directly, else -> PAD.
  - If src_q = 1, cnt_q <= 0 on RST_UARCH entry.
- PAD: -> IDLE when cnt_q + 1 >= pad_q.
- Counter:
  - cnt_q increments every non-IDLE cycle, saturating at 2^PadWidth-1 with no wrap.
  - Comparison uses a PadWidth+1 bit sum, so no overflow at max pad.
  - pad_q = 0 or 1 means no padding.
- Latency: with src 0, non-IDLE cycles = max(pad_q, F + RstCycles), where F = cycles in FLUSH_DCACHE.
- halt_o = fence_active_o = (state != IDLE).
- done_o is Mealy: state_q != IDLE and state_d == IDLE. Its cycle coincides with the final non-IDLE cycle.
- dropped_o = fence_t_i and state_q != IDLE (same cycle). The request is discarded, not queued. A fence_t_i on the done_o cycle is also dropped.
- A new fence_t_i is accepted on the first IDLE cycle.
- state_o and elapsed_o are registered values.

Test Plan:
- pad=0, src=0, RstCycles=4, ack 3 cycles after start:
  - states 1,1,1,2,2,2,2 then IDLE.
  - done_o on the 7th non-IDLE cycle; rst_uarch_o high exactly 4 cycles.
- pad=20, src=0, ack after 2 cycles:
  - PAD entered after RST_UARCH; exactly 20 non-IDLE cycles.
  - done_o in cycle 20; elapsed_o = 19 on that cycle.
- pad=10, src=1, ack after 5 cycles:
  - 5 + 10 = 15 non-IDLE cycles; cnt restarts at RST_UARCH entry.
- Ack in first FLUSH_DCACHE cycle, and fence_t_i repeated at cycles 2 and on the done cycle:
  - dropped_o pulses twice; only one sequence runs.
  - Next fence_t_i in IDLE starts a new sequence.
- rst_i asserted during RST_UARCH:
  - next cycle state_o = 0, rst_uarch_o = 0, halt_o = 0, no done_o.
  - A subsequent fence with pad=0 completes normally.
- pad=2^32-1, PadWidth=32, forced counter near max:
  - counter saturates without wrap; no premature exit.
  - Exit occurs when cnt_q + 1 = pad_q.

Source files
------------

// File: rtl/fence_t_sequencer_if.sv
// Handshake bundle between commit/CSR logic and the fence.t sequencer.
// Signal names keep the core's _i/_o suffixes as seen from the sequencer.
interface fence_t_sequencer_if #(
    parameter int PadWidth = 32
);
    logic                fence_t_i;
    logic [PadWidth-1:0] fence_t_pad_i;
    logic                fence_t_src_sel_i;
    logic                flush_dcache_ack_i;
    logic                flush_dcache_o;
    logic                rst_uarch_o;
    logic                halt_o;
    logic                fence_active_o;
    logic                done_o;
    logic                dropped_o;
    logic [1:0]          state_o;
    logic [PadWidth-1:0] elapsed_o;

    modport master (
        output fence_t_i, fence_t_pad_i, fence_t_src_sel_i, flush_dcache_ack_i,
        input  flush_dcache_o, rst_uarch_o, halt_o, fence_active_o, done_o,
               dropped_o, state_o, elapsed_o
    );

    modport slave (
        input  fence_t_i, fence_t_pad_i, fence_t_src_sel_i, flush_dcache_ack_i,
        output flush_dcache_o, rst_uarch_o, halt_o, fence_active_o, done_o,
               dropped_o, state_o, elapsed_o
    );
endinterface

// File: rtl/fence_t_sequencer.sv
// Temporal-fence flush sequencer: D-cache flush, uarch reset hold, then pad
// so the whole fence takes a constant, CSR-programmed number of cycles.
module fence_t_sequencer #(
    parameter int PadWidth  = 32,
    parameter int RstCycles = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fence_t_sequencer_if.slave  bus
);
    localparam int RcW = (RstCycles > 1) ? $clog2(RstCycles) : 1;
    localparam logic [RcW-1:0] RstLast = RcW'(RstCycles - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        FLUSH_DCACHE = 2'd1,
        RST_UARCH    = 2'd2,
        PAD          = 2'd3
    } state_e;

    state_e              r_state, w_state_d;
    logic [PadWidth-1:0] r_cnt, r_pad, w_cnt_inc;
    logic [RcW-1:0]      r_rst_cnt;
    logic                r_src;
    logic                w_start, w_rst_entry, w_pad_met;
    logic [PadWidth:0]   w_cnt_p1;

    // One extra bit keeps cnt+1 >= pad correct when pad is all ones.
    assign w_cnt_p1  = {1'b0, r_cnt} + (PadWidth+1)'(1);
    assign w_pad_met = w_cnt_p1 >= {1'b0, r_pad};
    assign w_cnt_inc = w_cnt_p1[PadWidth] ? r_cnt : w_cnt_p1[PadWidth-1:0];

    always_comb begin
        w_state_d   = r_state;
        w_start     = 1'b0;
        w_rst_entry = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.fence_t_i) begin
                    w_state_d = FLUSH_DCACHE;
                    w_start   = 1'b1;
                end
            end
            FLUSH_DCACHE: begin
                if (bus.flush_dcache_ack_i) begin
                    w_state_d   = RST_UARCH;
                    w_rst_entry = 1'b1;
                end
            end
            RST_UARCH: begin
                if (r_rst_cnt == RstLast) w_state_d = w_pad_met ? IDLE : PAD;
            end
            PAD: begin
                if (w_pad_met) w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rst_cnt <= '0;
            r_pad     <= '0;
            r_src     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            // CSR values are snapshotted so mid-fence writes cannot move the target.
            if (w_start) begin
                r_pad <= bus.fence_t_pad_i;
                r_src <= bus.fence_t_src_sel_i;
                r_cnt <= '0;
            end else if (w_rst_entry && r_src) begin
                r_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_rst_entry)                r_rst_cnt <= '0;
            else if (r_state == RST_UARCH)  r_rst_cnt <= r_rst_cnt + RcW'(1);
        end
    end

    assign bus.flush_dcache_o = (r_state == FLUSH_DCACHE);
    assign bus.rst_uarch_o    = (r_state == RST_UARCH);
    assign bus.fence_active_o = (r_state != IDLE);
    assign bus.halt_o         = (r_state != IDLE);
    assign bus.done_o         = (r_state != IDLE) && (w_state_d == IDLE);
    assign bus.dropped_o      = bus.fence_t_i && (r_state != IDLE);
    assign bus.state_o        = r_state;
    assign bus.elapsed_o      = r_cnt;
endmodule

// File: tb/tb_fence_t_sequencer.sv
// Bench for fence_t_sequencer: vector table feeding a scoreboard checked on
// done_o, plus directed drop, reset-abort and counter-saturation sequences.
module tb_fence_t_sequencer;
    localparam int PW = 32;
    localparam int RC = 4;
    localparam logic [PW-1:0] MAXV = '1;

    typedef struct { logic [PW-1:0] pad; bit src; int f; } vec_t;
    typedef struct { int len; int rstc; int padc; logic [PW-1:0] last_el; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fence_t_sequencer_if #(.PadWidth(PW)) bus ();
    fence_t_sequencer #(.PadWidth(PW), .RstCycles(RC)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t cur;
    bit   mon_en = 1'b0;
    int   m_len = 0, m_rst = 0, m_pad = 0, drops = 0;
    vec_t tv[8];

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: src 0 counts from fence start, src 1 from RST_UARCH entry.
    function automatic exp_t model(logic [PW-1:0] pad, bit src, int f);
        exp_t   e;
        longint p = pad;
        longint tail;
        if (src) begin
            tail      = (p > RC) ? p : RC;
            e.len     = f + int'(tail);
            e.last_el = PW'(tail - 1);
        end else begin
            e.len     = (p > f + RC) ? int'(p) : f + RC;
            e.last_el = PW'(e.len - 1);
        end
        e.rstc = RC;
        e.padc = e.len - f - RC;
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.dropped_o) drops++;
        if (rst || !mon_en) begin
            m_len = 0; m_rst = 0; m_pad = 0;
        end else if (bus.state_o != 2'd0) begin
            m_len++;
            if (bus.rst_uarch_o) m_rst++;
            if (bus.state_o == 2'd3) m_pad++;
            if (bus.done_o) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    chk("len", m_len, cur.len);
                    chk("rst_cycles", m_rst, cur.rstc);
                    chk("pad_cycles", m_pad, cur.padc);
                    chk("elapsed_at_done", bus.elapsed_o, cur.last_el);
                end
                m_len = 0; m_rst = 0; m_pad = 0;
            end
        end
    end

    task automatic wait_idle(string nm);
        int n = 0;
        while (bus.state_o != 2'd0 && n < 400) begin
            tick();
            n++;
        end
        if (bus.state_o != 2'd0) chk(nm, bus.state_o, 0);
    endtask

    task automatic run_vec(logic [PW-1:0] pad, bit src, int f);
        sb.push_back(model(pad, src, f));
        bus.fence_t_pad_i     = pad;
        bus.fence_t_src_sel_i = src;
        bus.fence_t_i         = 1'b1;
        tick();
        bus.fence_t_i         = 1'b0;
        bus.fence_t_pad_i     = ~pad;
        bus.fence_t_src_sel_i = ~src;
        for (int k = 1; k <= f; k++) begin
            bus.flush_dcache_ack_i = (k == f);
            tick();
        end
        bus.flush_dcache_ack_i = 1'b0;
        wait_idle("seq_timeout");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  rc;
        bit  got, sawpad;
        bus.fence_t_i          = 1'b0;
        bus.fence_t_pad_i      = '0;
        bus.fence_t_src_sel_i  = 1'b0;
        bus.flush_dcache_ack_i = 1'b0;
        tv[0] = '{32'd0,  1'b0, 3};
        tv[1] = '{32'd20, 1'b0, 2};
        tv[2] = '{32'd10, 1'b1, 5};
        tv[3] = '{32'd1,  1'b0, 1};
        tv[4] = '{32'd5,  1'b0, 1};
        tv[5] = '{32'd6,  1'b0, 1};
        tv[6] = '{32'd3,  1'b1, 2};
        tv[7] = '{32'd7,  1'b0, 4};

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_state", bus.state_o, 0);
        chk("rst_outs", {bus.flush_dcache_o, bus.rst_uarch_o, bus.halt_o,
                         bus.fence_active_o, bus.done_o, bus.dropped_o}, 0);
        chk("rst_elapsed", bus.elapsed_o, 0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        bus.flush_dcache_ack_i = 1'b1;
        tick(); tick();
        chk("ack_in_idle", bus.state_o, 0);
        bus.flush_dcache_ack_i = 1'b0;

        foreach (tv[i]) run_vec(tv[i].pad, tv[i].src, tv[i].f);

        // Drops: ack on first FLUSH cycle, fence_t_i again at cycle 2 and on done.
        drops = 0;
        sb.push_back(model(32'd0, 1'b0, 1));
        bus.fence_t_pad_i = '0; bus.fence_t_src_sel_i = 1'b0; bus.fence_t_i = 1'b1;
        tick();
        bus.fence_t_i = 1'b0; bus.flush_dcache_ack_i = 1'b1;
        tick();
        bus.flush_dcache_ack_i = 1'b0; bus.fence_t_i = 1'b1;
        #1 chk("drop_cycle2", bus.dropped_o, 1);
        tick();
        bus.fence_t_i = 1'b0;
        tick(); tick();
        bus.fence_t_i = 1'b1;
        #1 chk("done_cycle5", bus.done_o, 1);
        chk("drop_on_done", bus.dropped_o, 1);
        tick();
        bus.fence_t_i = 1'b0;
        chk("no_restart", bus.state_o, 0);
        chk("drop_count", drops, 2);
        run_vec(32'd0, 1'b0, 2);

        // Reset while in RST_UARCH aborts without done_o.
        bus.fence_t_pad_i = '0; bus.fence_t_src_sel_i = 1'b0; bus.fence_t_i = 1'b1;
        tick();
        bus.fence_t_i = 1'b0; bus.flush_dcache_ack_i = 1'b1;
        tick();
        bus.flush_dcache_ack_i = 1'b0;
        tick();
        chk("pre_rst_state", bus.state_o, 2);
        rst = 1'b1;
        tick();
        chk("abort_state", bus.state_o, 0);
        chk("abort_outs", {bus.rst_uarch_o, bus.halt_o, bus.done_o}, 0);
        rst = 1'b0;
        tick();
        run_vec(32'd0, 1'b0, 1);

        // Counter pinned at max in FLUSH: must hold, then exit after RST_UARCH.
        mon_en = 1'b0;
        bus.fence_t_pad_i = MAXV; bus.fence_t_src_sel_i = 1'b0; bus.fence_t_i = 1'b1;
        tick();
        bus.fence_t_i = 1'b0;
        force dut.r_cnt = MAXV;
        tick();
        release dut.r_cnt;
        tick(); tick();
        chk("sat_hold", bus.elapsed_o, MAXV);
        chk("sat_state", bus.state_o, 1);
        bus.flush_dcache_ack_i = 1'b1;
        tick();
        bus.flush_dcache_ack_i = 1'b0;
        rc = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.rst_uarch_o) rc++;
            if (bus.done_o) begin
                got = 1'b1;
                chk("sat_exit_state", bus.state_o, 2);
            end else tick();
        end
        chk("sat_done", got, 1);
        chk("sat_rst_cycles", rc, RC);
        tick();
        chk("sat_idle_el", bus.elapsed_o, MAXV);

        // Counter just below max: PAD must run until cnt+1 == pad.
        bus.fence_t_pad_i = MAXV; bus.fence_t_i = 1'b1;
        tick();
        bus.fence_t_i = 1'b0;
        force dut.r_cnt = MAXV - 32'd8;
        tick();
        release dut.r_cnt;
        bus.flush_dcache_ack_i = 1'b1;
        tick();
        bus.flush_dcache_ack_i = 1'b0;
        sawpad = 1'b0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.state_o == 2'd3) sawpad = 1'b1;
            if (bus.done_o) begin
                got = 1'b1;
                chk("nearmax_el", bus.elapsed_o, MAXV - 32'd1);
            end else tick();
        end
        chk("nearmax_done", got, 1);
        chk("nearmax_pad", sawpad, 1);
        tick();
        chk("nearmax_idle", bus.state_o, 0);
        chk("nearmax_idle_el", bus.elapsed_o, MAXV);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
